// File: rtl/bcd_pkg.sv
// -----------------------------------------------------------------------------
// bcd_pkg
// Shared definitions for the sequential binary-to-BCD converter:
//   - default binary input width and BCD digit count
//   - BCD_MAX, the largest value representable in DIGITS decimal digits
//   - FSM state encoding
//   - ITERS, the number of shift-add-3 iterations per conversion
// -----------------------------------------------------------------------------
package bcd_pkg;

  localparam int BIN_WIDTH_DEF = 27;
  localparam int DIGITS_DEF    = 8;

  // One double-dabble iteration per input bit.
  localparam int ITERS = BIN_WIDTH_DEF;

  // 10^digits - 1, evaluated at elaboration time.
  function automatic longint unsigned pow10_minus1(input int digits);
    longint unsigned p;
    p = 1;
    for (int i = 0; i < digits; i++) p = p * 10;
    return p - 1;
  endfunction

  localparam longint unsigned BCD_MAX = pow10_minus1(DIGITS_DEF);  // 99_999_999

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

endpackage

// File: rtl/bcd_digit_adjust.sv
// -----------------------------------------------------------------------------
// bcd_digit_adjust
// Combinational add-3 step of the double-dabble algorithm for one BCD digit:
// a digit of 5 or more gets +3 so that the following left shift carries
// correctly into the next decimal digit.
// Ports:
//   digit     in   [3:0]  current BCD digit
//   adjusted  out  [3:0]  digit + 3 if digit >= 5, else digit (no carry out)
// -----------------------------------------------------------------------------
module bcd_digit_adjust (
  input  logic [3:0] digit,
  output logic [3:0] adjusted
);

  assign adjusted = (digit >= 4'd5) ? digit + 4'd3 : digit;

endmodule

// File: rtl/seq_binary_to_bcd.sv
// -----------------------------------------------------------------------------
// seq_binary_to_bcd
// Iterative shift-add-3 converter from an unsigned binary value to packed BCD.
// Values above 10^DIGITS-1 are clamped and flagged. One iteration per clock;
// the result register is only written on completion, so downstream display
// logic always sees a complete, stable value.
// Ports:
//   clock      in              system clock, rising edge
//   reset_n    in              asynchronous active-low reset
//   in_valid   in              binary_in is valid this cycle
//   in_ready   out             block is idle and can accept a value
//   binary_in  in  [BIN_WIDTH] unsigned value to convert
//   bcd_out    out [4*DIGITS]  packed BCD result, digit 0 in [3:0], held
//   bcd_valid  out             one-cycle pulse, bcd_out updated on last edge
//   overflow   out             input was clamped; held with bcd_out
// -----------------------------------------------------------------------------
module seq_binary_to_bcd
  import bcd_pkg::*;
#(
  parameter int BIN_WIDTH = BIN_WIDTH_DEF,
  parameter int DIGITS    = DIGITS_DEF
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [BIN_WIDTH-1:0]  binary_in,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  bcd_valid,
  output logic                  overflow
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(BIN_WIDTH);
  localparam logic [BIN_WIDTH-1:0] MAX_VAL   = BIN_WIDTH'(pow10_minus1(DIGITS));
  localparam logic [CNT_W-1:0]     LAST_ITER = CNT_W'(BIN_WIDTH - 1);

  state_t               state;
  logic [BIN_WIDTH-1:0] shift_reg;
  logic [BCD_W-1:0]     scratch;
  logic [CNT_W-1:0]     iter_cnt;
  logic                 ovf_pend;

  logic [BCD_W-1:0]     scratch_adj;
  logic [BCD_W-1:0]     scratch_next;
  logic [BIN_WIDTH-1:0] shift_next;
  logic [BIN_WIDTH-1:0] clamped_in;
  logic                 in_over;

  // Add-3 on every digit, then shift {scratch, shift_reg} left by one.
  for (genvar d = 0; d < DIGITS; d++) begin : g_adjust
    bcd_digit_adjust u_adjust (
      .digit    (scratch[4*d +: 4]),
      .adjusted (scratch_adj[4*d +: 4])
    );
  end

  assign scratch_next = {scratch_adj[BCD_W-2:0], shift_reg[BIN_WIDTH-1]};
  assign shift_next   = {shift_reg[BIN_WIDTH-2:0], 1'b0};

  assign in_over    = (binary_in > MAX_VAL);
  assign clamped_in = in_over ? MAX_VAL : binary_in;

  // Decoded straight from the state register, so it reads 1 during reset too.
  assign in_ready = (state == IDLE);

  // NOTE: every register here is written with <= so all flops update from the
  // same pre-edge values; blocking = would let later statements see new state.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      shift_reg <= '0;
      scratch   <= '0;
      iter_cnt  <= '0;
      ovf_pend  <= 1'b0;
      bcd_out   <= '0;
      overflow  <= 1'b0;
      bcd_valid <= 1'b0;
    end else begin
      bcd_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid) begin
            shift_reg <= clamped_in;
            ovf_pend  <= in_over;
            scratch   <= '0;
            iter_cnt  <= '0;
            state     <= SHIFT;
          end
        end
        SHIFT: begin
          scratch   <= scratch_next;
          shift_reg <= shift_next;
          if (iter_cnt == LAST_ITER) begin
            // Final iteration: publish the finished digits in the same edge.
            bcd_out   <= scratch_next;
            overflow  <= ovf_pend;
            bcd_valid <= 1'b1;
            iter_cnt  <= '0;
            state     <= IDLE;
          end else begin
            iter_cnt <= iter_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/seq_binary_to_bcd.md
Name: seq_binary_to_bcd

Overview:
Iterative (shift-add-3 / double-dabble) converter from a 27-bit unsigned binary value to 8 packed BCD digits.
Sits directly upstream of seven_seg_fsm and replaces the combinational converter on its input path.
Output is a held register, so the display scan always reads a stable, complete result.
Uses a valid/ready input handshake and a one-cycle done pulse.

Parameters:
BIN_WIDTH, 27, width of the binary input.
DIGITS, 8, number of BCD digits produced. Output width is 4*DIGITS.

Ports:
clock  input  1  system clock; all state changes on its rising edge.
reset_n  input  1  asynchronous, active-low reset.
in_valid  input  1  binary_in is valid this cycle.
in_ready  output  1  high when the block can accept a value (state IDLE).
binary_in  input  BIN_WIDTH  unsigned value to convert.
bcd_out  output  4*DIGITS  packed BCD result; digit 0 (least significant) in [3:0]; held until the next completion.
bcd_valid  output  1  one-cycle pulse: bcd_out was updated on the previous edge.
overflow  output  1  set with each result: 1 if the input exceeded 10^DIGITS-1 and was clamped; held with bcd_out.

Behaviour:
- Clock is one clock; reset is asynchronous and active-low. Ports are named clock and reset_n.
- Reset (reset_n=0, applied immediately regardless of clock):
  - state goes to IDLE; bcd_out=0; overflow=0; bcd_valid=0.
  - working registers are cleared; iteration counter=0.
  - in_ready reads 1 in IDLE, including while reset is held.
  - any conversion in progress is abandoned, with no bcd_valid pulse.
- States:
  - IDLE: in_ready=1.
  - SHIFT: in_ready=0.
- Accept rule: on an edge in IDLE with in_valid=1 (call it edge T0):
  - capture min(binary_in, BCD_MAX) into the shift register, where BCD_MAX = 99_999_999.
  - record the overflow flag (binary_in > BCD_MAX).
  - clear the BCD scratch and the counter; go to SHIFT.
- SHIFT, once per edge:
  - every scratch digit >= 5 gets +3 (4-bit add, no carry out).
  - then shift {scratch, shift_reg} left by 1.
  - counter increments.
- Completion:
  - the edge performing iteration BIN_WIDTH (edge T0+27) also loads bcd_out with the final scratch and loads overflow.
  - on the same edge: bcd_valid <= 1 for exactly one cycle; state returns to IDLE.
  - Latency: accept edge to bcd_valid high = 27 edges (constant, independent of value or clamping).
  - Throughput: one conversion per 28 cycles. A new value may be accepted on the edge that ends the bcd_valid cycle (back-to-back).
- in_valid while in SHIFT is ignored and not queued. binary_in changes after acceptance have no effect.
- bcd_out and overflow never change except at completion or reset. No partial results are ever visible.
- Width rules:
  - clamped values are <= 99_999_999 < 2^27, so 8 digits never overflow during the adjust.
  - scratch width = 4*DIGITS; counter width = 5 bits (counts 0..26).
- Boundary cases:
  - input 0 gives all-zero digits.
  - input exactly BCD_MAX: overflow=0.
  - input 2^27-1: clamped to 99999999, overflow=1.

Decomposition:
- Shared package bcd_pkg holds:
  - BIN_WIDTH and DIGITS defaults.
  - BCD_MAX constant (10^DIGITS-1).
  - state encoding (IDLE, SHIFT).
  - iteration-count constant ITERS = BIN_WIDTH.
- One natural sub-module: bcd_digit_adjust.
  - Combinational, one 4-bit digit in and one out: adds 3 if the digit is >= 5.
  - Instantiated DIGITS times by a generate loop.

Test Plan:
- Reset, then binary_in=0 with in_valid for one cycle → in_ready=0 for 27 cycles; bcd_valid pulses at T0+27; bcd_out=0x00000000, overflow=0.
- binary_in=12_345_678 → bcd_out=0x12345678 at T0+27, overflow=0; bcd_out then holds for 100 cycles with in_valid=0.
- binary_in=99_999_999 → 0x99999999, overflow=0. binary_in=134_217_727 → 0x99999999, overflow=1. binary_in=100_000_000 → 0x99999999, overflow=1.
- Accept 255, then hold in_valid=1 with binary_in=7 during SHIFT:
  - 255 result 0x00000255 appears; 7 is accepted on the edge after the bcd_valid cycle.
  - 0x00000007 arrives 28 cycles after the first bcd_valid.
  - exactly 2 bcd_valid pulses in total.
- Start a conversion of 42, assert reset_n=0 mid-cycle at T0+10 (between clock edges):
  - outputs clear immediately; no bcd_valid pulse follows.
  - after release, in_ready=1 and a fresh conversion of 9 gives 0x00000009.
